// File: rtl/branch_pc_unit.sv
// Next-PC / branch-resolution stage: owns the PC, Z/N flags, link request,
// taken-branch counter and sticky misaligned-target error.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       status,
    input  logic             alu_zero,
    input  logic [31:0]      alu_result,
    input  logic             flag_we,
    input  logic [31:0]      imm_ext,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             link_we,
    output logic [4:0]       link_addr,
    output logic [31:0]      link_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic [CNT_W-1:0] taken_count,
    output logic             misalign_err
);

    localparam logic [2:0] ST_SEQ   = 3'b000;
    localparam logic [2:0] ST_BMN   = 3'b001;
    localparam logic [2:0] ST_BRZ   = 3'b010;
    localparam logic [2:0] ST_BZ    = 3'b011;
    localparam logic [2:0] ST_JMOR  = 3'b100;
    localparam logic [2:0] ST_JALM  = 3'b101;
    localparam logic [2:0] ST_JSPAL = 3'b110;
    localparam logic [2:0] ST_BEQ   = 3'b111;

    logic [31:0] br_tgt;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign br_tgt    = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign link_addr = 5'd31;
    assign link_data = pc_plus4;
    assign link_we   = ((status == ST_JALM) || (status == ST_JSPAL)) && !stall && rst_n;

    // Conditional branches test the registered flags, never this cycle's update.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        case (status)
            ST_SEQ:   begin taken = 1'b0;     target = pc_plus4;  end
            ST_BMN:   begin taken = flag_n;   target = mem_rdata; end
            ST_BRZ:   begin taken = flag_z;   target = rs_data;   end
            ST_BZ:    begin taken = flag_z;   target = br_tgt;    end
            ST_JMOR:  begin taken = 1'b1;     target = mem_rdata; end
            ST_JALM:  begin taken = 1'b1;     target = mem_rdata; end
            ST_JSPAL: begin taken = 1'b1;     target = rs_data;   end
            ST_BEQ:   begin taken = alu_zero; target = br_tgt;    end
            default:  begin taken = 1'b0;     target = pc_plus4;  end
        endcase
    end

    assign next_pc = taken ? {target[31:2], 2'b00} : pc_plus4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            taken_count  <= '0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (flag_we) begin
                flag_z <= (alu_result == 32'd0);
                flag_n <= alu_result[31];
            end
            if (taken) begin
                taken_count <= taken_count + 1'b1;
            end
            if (taken && (target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus randomized
// traffic compared against a behavioural next-PC model.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  status;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic        flag_we;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] taken_count;
    logic        misalign_err;

    int checks;
    int errors;

    // reference model state
    logic [31:0] m_pc;
    logic        m_z;
    logic        m_n;
    logic [15:0] m_cnt;
    logic        m_err;

    branch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .status(status),
        .alu_zero(alu_zero), .alu_result(alu_result), .flag_we(flag_we),
        .imm_ext(imm_ext), .rs_data(rs_data), .mem_rdata(mem_rdata),
        .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .link_we(link_we),
        .link_addr(link_addr), .link_data(link_data), .flag_z(flag_z),
        .flag_n(flag_n), .taken_count(taken_count), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Redirect decision from the instruction table, using the flags as they stand.
    function automatic logic model_taken();
        case (status)
            3'd1:    return m_n;
            3'd2:    return m_z;
            3'd3:    return m_z;
            3'd4, 3'd5, 3'd6: return 1'b1;
            3'd7:    return alu_zero;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target();
        logic [31:0] rel;
        rel = m_pc + 32'd4 + imm_ext * 32'd4;
        case (status)
            3'd1, 3'd4, 3'd5: return mem_rdata;
            3'd2, 3'd6:       return rs_data;
            default:          return rel;
        endcase
    endfunction

    function automatic logic model_link();
        return (status == 3'd5 || status == 3'd6) && !stall && rst_n;
    endfunction

    task automatic set_in(input logic [2:0] st, input logic [31:0] mem,
                          input logic [31:0] rs, input logic [31:0] imm,
                          input logic az, input logic fwe, input logic [31:0] res,
                          input logic stl);
        status = st; mem_rdata = mem; rs_data = rs; imm_ext = imm;
        alu_zero = az; flag_we = fwe; alu_result = res; stall = stl;
        #1;
    endtask

    // Advance one clock edge and move the model the same way.
    task automatic tick();
        logic        t;
        logic [31:0] tg;
        t  = model_taken();
        tg = model_target();
        @(posedge clk);
        if (!rst_n) begin
            m_pc = 32'h0; m_z = 1'b0; m_n = 1'b0; m_cnt = 16'h0; m_err = 1'b0;
        end else if (!stall) begin
            m_pc = t ? (tg & 32'hFFFF_FFFC) : m_pc + 32'd4;
            if (flag_we) begin
                m_z = (alu_result == 32'd0);
                m_n = alu_result[31];
            end
            if (t) m_cnt = m_cnt + 16'd1;
            if (t && (tg % 4 != 0)) m_err = 1'b1;
        end
        #1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(3'd4, 32'h123, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        checks++;
        if (link_we !== 1'b0) begin
            errors++; $display("FAIL reset_link_we got %0b want 0", link_we);
        end
        tick();
        tick();
        checks++;
        if (pc !== 32'h0 || flag_z !== 1'b0 || flag_n !== 1'b0 ||
            taken_count !== 16'h0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pc=%h z=%b n=%b cnt=%h err=%b want all zero",
                     pc, flag_z, flag_n, taken_count, misalign_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            set_in(3'd0, 32'hDEAD_BEEF, 32'h55, 32'h7, 1'b1, 1'b0, 32'h0, 1'b0);
            checks++;
            if (taken !== 1'b0 || link_we !== 1'b0) begin
                errors++; $display("FAIL seq_comb got taken=%b link_we=%b want 0 0", taken, link_we);
            end
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++;
            if (pc !== exp_pc || taken_count !== 16'h0) begin
                errors++; $display("FAIL seq_pc got pc=%h cnt=%h want pc=%h cnt=0", pc, taken_count, exp_pc);
            end
        end
    endtask

    task automatic test_beq();
        set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();  // pc 0x10
        set_in(3'd7, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (taken !== 1'b1) begin
            errors++; $display("FAIL beq_taken got %b want 1", taken);
        end
        tick();
        checks++;
        if (pc !== 32'h0C || taken_count !== 16'd1) begin
            errors++; $display("FAIL beq_target got pc=%h cnt=%h want pc=0000000c cnt=1", pc, taken_count);
        end
        set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();  // pc 0x10
        set_in(3'd7, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (pc !== 32'h14 || taken_count !== 16'd1) begin
            errors++; $display("FAIL beq_not_taken got pc=%h cnt=%h want pc=00000014 cnt=1", pc, taken_count);
        end
    endtask

    task automatic test_flag_timing();
        set_in(3'd1, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
        checks++;
        if (taken !== 1'b0) begin
            errors++; $display("FAIL flag_old_value got taken=%b want 0", taken);
        end
        tick();
        checks++;
        if (pc !== 32'h18 || flag_n !== 1'b1 || flag_z !== 1'b0) begin
            errors++; $display("FAIL flag_update got pc=%h n=%b z=%b want pc=00000018 n=1 z=0", pc, flag_n, flag_z);
        end
        set_in(3'd1, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (pc !== 32'h200) begin
            errors++; $display("FAIL bmn_taken got pc=%h want 00000200", pc);
        end
    endtask

    task automatic test_link();
        set_in(3'd4, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(3'd5, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (link_we !== 1'b1 || link_addr !== 5'd31 || link_data !== 32'h44) begin
            errors++; $display("FAIL jalm_link got we=%b addr=%0d data=%h want 1 31 00000044", link_we, link_addr, link_data);
        end
        tick();
        checks++;
        if (pc !== 32'h1000) begin
            errors++; $display("FAIL jalm_pc got %h want 00001000", pc);
        end
        set_in(3'd6, 32'h0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (link_we !== 1'b1 || link_data !== 32'h1004) begin
            errors++; $display("FAIL jspal_link got we=%b data=%h want 1 00001004", link_we, link_data);
        end
        tick();
        checks++;
        if (pc !== 32'h2000) begin
            errors++; $display("FAIL jspal_pc got %h want 00002000", pc);
        end
    endtask

    task automatic test_misalign_stall();
        logic [15:0] cnt_before;
        set_in(3'd4, 32'h303, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (pc !== 32'h300 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL misalign_set got pc=%h err=%b want 00000300 1", pc, misalign_err);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        checks++;
        if (misalign_err !== 1'b1 || pc !== 32'h314) begin
            errors++; $display("FAIL misalign_sticky got err=%b pc=%h want 1 00000314", misalign_err, pc);
        end
        cnt_before = m_cnt;
        set_in(3'd5, 32'h500, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        checks++;
        if (taken !== 1'b1 || link_we !== 1'b0) begin
            errors++; $display("FAIL stall_comb got taken=%b link_we=%b want 1 0", taken, link_we);
        end
        tick();
        checks++;
        if (pc !== 32'h314 || taken_count !== cnt_before || flag_z !== m_z) begin
            errors++; $display("FAIL stall_hold got pc=%h cnt=%h z=%b want 00000314 %h %b",
                               pc, taken_count, flag_z, cnt_before, m_z);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            set_in(3'd4, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        checks++;
        if (taken_count !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_full got %h want ffff", taken_count);
        end
        set_in(3'd4, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checks++;
        if (taken_count !== 16'h0000 || pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL cnt_wrap got cnt=%h pc=%h want 0000 fffffffc", taken_count, pc);
        end
        set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL pc4_wrap got %h want 00000000", pc_plus4);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL pc_wrap got %h want 00000000", pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_p4;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            set_in(3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFC),
                   $urandom & 32'h0000_FFFC,
                   32'($signed(16'($urandom))),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                   ($urandom_range(0, 7) == 0));
            exp_p4 = m_pc + 32'd4;
            checks++;
            if (taken !== model_taken() || link_we !== model_link() ||
                pc_plus4 !== exp_p4 || link_data !== exp_p4) begin
                errors++;
                $display("FAIL rand_comb[%0d] got taken=%b link_we=%b pc4=%h want %b %b %h",
                         i, taken, link_we, pc_plus4, model_taken(), model_link(), exp_p4);
            end
            tick();
            checks++;
            if (pc !== m_pc || flag_z !== m_z || flag_n !== m_n ||
                taken_count !== m_cnt || misalign_err !== m_err) begin
                errors++;
                $display("FAIL rand_state[%0d] got pc=%h z=%b n=%b cnt=%h err=%b want %h %b %b %h %b",
                         i, pc, flag_z, flag_n, taken_count, misalign_err, m_pc, m_z, m_n, m_cnt, m_err);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_pc = 32'h0; m_z = 1'b0; m_n = 1'b0; m_cnt = 16'h0; m_err = 1'b0;
        rst_n = 1'b0;
        set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_beq();
        test_flag_timing();
        test_link();
        test_misalign_stall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
